multicycle_ctrl: RTL

- Moore/Mealy FSM that sequences a multicycle RV32I-subset datapath built from the existing pc, Instruction_mem, Reg_mem, alu, Alu_Control, immGen and data_mem blocks.
- Generates per-state enables and mux selects: IR/PC write, memory address select, ALU operand selects, ALU op, register writeback.
- Handles variable-latency memory through a req/ack handshake with a timeout.
- Provides halt and illegal-instruction detection, plus cycle and retired-instruction counters.

---
 rtl/multicycle_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM sequencing a multicycle RV32I-subset datapath,
// with a timed memory handshake, halt/illegal detection and saturating counters.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic             alu_zero_i,
    input  logic             end_file_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             ir_write_o,
    output logic             ior_d_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             reg_write_o,
    output logic             mem_to_reg_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             pc_source_o,
    output logic             halted_o,
    output logic             error_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [CNT_W-1:0] instr_count_o
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
        EXEC_R, EXEC_I, ALU_WB, BRANCH, HALT, ERROR
    } state_t;
    localparam int WW = $clog2(TIMEOUT + 1);
    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] cycle_q, instr_q;
    logic [12:0]      ctl_q, ctl_d;
    logic             waiting, timed_out, taken, retire, active;
    assign waiting   = (state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR) && !mem_ack_i;
    assign timed_out = waiting && wait_q == WW'(TIMEOUT - 1);
    assign taken     = (funct3_i == 3'b000 && alu_zero_i) || (funct3_i == 3'b001 && !alu_zero_i);
    assign retire    = state_d == FETCH && (state_q == MEM_WB || state_q == MEM_WR || state_q == ALU_WB || state_q == BRANCH);
    assign active    = !(state_q == IDLE || state_q == HALT || state_q == ERROR);
    assign wait_d    = (state_d == state_q && waiting) ? wait_q + WW'(1) : '0;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = FETCH;
            FETCH:    state_d = end_file_i ? HALT : mem_ack_i ? DECODE : timed_out ? ERROR : FETCH;
            DECODE:   state_d = (opcode_i == 7'b0000011 || opcode_i == 7'b0100011) ? MEM_ADDR :
                                opcode_i == 7'b0110011 ? EXEC_R :
                                opcode_i == 7'b0010011 ? EXEC_I :
                                opcode_i == 7'b1100011 ? BRANCH : ERROR;
            MEM_ADDR: state_d = opcode_i == 7'b0000011 ? MEM_RD : MEM_WR;
            MEM_RD:   state_d = mem_ack_i ? MEM_WB : timed_out ? ERROR : MEM_RD;
            MEM_WR:   state_d = mem_ack_i ? FETCH : timed_out ? ERROR : MEM_WR;
            EXEC_R, EXEC_I:         state_d = ALU_WB;
            MEM_WB, ALU_WB, BRANCH: state_d = FETCH;
            HALT, ERROR:            state_d = state_q;
            default:                state_d = ERROR;
        endcase
    end
    // {iorD, memRead, memWrite, regWrite, memToReg, aluSrcA, aluSrcB, aluOp, pcSource, halted, error}
    always_comb begin
        ctl_d = '0;
        case (state_d)
            FETCH:    ctl_d = 13'b0_1_0_0_0_0_01_00_0_0_0;
            DECODE:   ctl_d = 13'b0_0_0_0_0_0_10_00_0_0_0;
            MEM_ADDR: ctl_d = 13'b0_0_0_0_0_1_10_00_0_0_0;
            MEM_RD:   ctl_d = 13'b1_1_0_0_0_0_00_00_0_0_0;
            MEM_WB:   ctl_d = 13'b0_0_0_1_1_0_00_00_0_0_0;
            MEM_WR:   ctl_d = 13'b1_0_1_0_0_0_00_00_0_0_0;
            EXEC_R:   ctl_d = 13'b0_0_0_0_0_1_00_10_0_0_0;
            EXEC_I:   ctl_d = 13'b0_0_0_0_0_1_10_11_0_0_0;
            ALU_WB:   ctl_d = 13'b0_0_0_1_0_0_00_00_0_0_0;
            BRANCH:   ctl_d = 13'b0_0_0_0_0_1_00_01_1_0_0;
            HALT:     ctl_d = 13'b0_0_0_0_0_0_00_00_0_1_0;
            ERROR:    ctl_d = 13'b0_0_0_0_0_0_00_00_0_0_1;
            default:  ctl_d = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            cycle_q <= '0;
            instr_q <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ctl_q   <= ctl_d;
            if (active && cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
            if (retire && instr_q != '1) instr_q <= instr_q + CNT_W'(1);
        end
    end
    // Load enables follow the live handshake so the IR/PC capture in the ack cycle.
    assign ir_write_o = state_q == FETCH && mem_ack_i && !end_file_i;
    assign pc_write_o = ir_write_o || (state_q == BRANCH && taken);
    assign {ior_d_o, mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o, alu_src_a_o,
            alu_src_b_o, alu_op_o, pc_source_o, halted_o, error_o} = ctl_q;
    assign state_o       = state_q;
    assign cycle_count_o = cycle_q;
    assign instr_count_o = instr_q;
endmodule
